// File: rtl/a25_copro15_ctrl_pkg.sv
// Shared encodings for the Amber 25 CP15 control block: register numbers, ops, flush states, fault record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package a25_copro15_ctrl_pkg;

  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  localparam logic [3:0] CRN_ID           = 4'd0;
  localparam logic [3:0] CRN_FLUSH        = 4'd1;
  localparam logic [3:0] CRN_CTRL         = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE    = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE   = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE   = 4'd5;
  localparam logic [3:0] CRN_FAULT_STATUS = 4'd6;
  localparam logic [3:0] CRN_FAULT_ADDR   = 4'd7;
  localparam logic [3:0] CRN_FAULT_POP    = 4'd8;
  localparam logic [3:0] CRN_FAULT_INFO   = 4'd9;

  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_REQ  = 1'b1
  } flush_state_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] address;
  } fault_t;

endpackage

// File: rtl/a25_copro15_ctrl_fault_fifo.sv
// Generic FIFO holding fault records; head is combinational from storage and reads as 0 when empty.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none upstream; a push into a full FIFO is dropped and sets a sticky overflow flag.
module a25_fault_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  input  logic                     clr_overflow,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop_vld && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_vld && full && !do_pop) overflow <= 1'b1;
      else if (clr_overflow)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/a25_copro15_ctrl.sv
// CP15 control for Amber 25: cache/region registers, MRC/MCR access, region lookup, flush handshake, fault queue.
// Latency: reads and lookups 1 cycle; writes land at the next edge; flush_req rises 1 cycle after a command.
// Backpressure: i_access_stall freezes register, FIFO, read and lookup state; the flush handshake keeps running.
module a25_copro15_ctrl
  import a25_copro15_ctrl_pkg::*;
#(
  parameter logic [3:0]  COPRO_NUM    = 4'd15,
  parameter int          REGION_BITS  = 32,
  parameter int          REGION_SHIFT = 21,
  parameter int          FAULT_DEPTH  = 4,
  parameter logic [31:0] ID_VALUE     = 32'h4156_0301
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_access_stall,
  input  logic [3:0]  i_copro_num,
  input  logic [3:0]  i_copro_crn,
  input  logic [1:0]  i_copro_operation,
  input  logic [31:0] i_copro_write_data,
  output logic [31:0] o_copro_read_data,
  input  logic        i_fault,
  input  logic [7:0]  i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic        i_access_valid,
  input  logic [31:0] i_access_address,
  output logic        o_access_cacheable,
  output logic        o_access_updateable,
  output logic        o_cache_enable,
  output logic        o_cache_flush_req,
  input  logic        i_cache_flush_ack,
  output logic        o_fault_pending
);

  localparam int IDX_W = (REGION_BITS > 1) ? $clog2(REGION_BITS) : 1;
  localparam int CNT_W = $clog2(FAULT_DEPTH) + 1;

  logic [2:0]             ctrl;
  logic [REGION_BITS-1:0] cacheable;
  logic [REGION_BITS-1:0] updateable;
  logic [REGION_BITS-1:0] disruptive;

  logic cp_vld;
  logic cp_wr;
  logic cp_rd;
  assign cp_vld = !i_access_stall && (i_copro_num == COPRO_NUM);
  assign cp_wr  = cp_vld && (i_copro_operation == OP_MCR);
  assign cp_rd  = cp_vld && (i_copro_operation == OP_MRC);

  // Region lookup: indices beyond the register width never hit.
  logic [31:0]      region_idx;
  logic [IDX_W-1:0] idx_lo;
  logic             idx_in_range;
  logic             lookup_vld;
  logic             hit_cacheable;
  logic             hit_updateable;
  logic             hit_disruptive;

  assign region_idx     = i_access_address >> REGION_SHIFT;
  assign idx_in_range   = (region_idx < 32'(REGION_BITS));
  assign idx_lo         = region_idx[IDX_W-1:0];
  assign lookup_vld     = i_access_valid && !i_access_stall;
  assign hit_cacheable  = idx_in_range && cacheable[idx_lo];
  assign hit_updateable = idx_in_range && updateable[idx_lo];
  assign hit_disruptive = idx_in_range && disruptive[idx_lo];

  logic flush_cmd;
  assign flush_cmd = (cp_wr && (i_copro_crn == CRN_FLUSH)) ||
                     (lookup_vld && ctrl[0] && hit_disruptive);

  // Fault queue.
  fault_t           fault_in;
  fault_t           fault_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_overflow;
  logic [7:0]       count8;

  assign fault_in = '{status: i_fault_status, address: i_fault_address};
  assign count8   = 8'(fifo_count);

  a25_fault_fifo #(
    .WIDTH ($bits(fault_t)),
    .DEPTH (FAULT_DEPTH)
  ) u_fault_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .push_vld     (i_fault && !i_access_stall),
    .push_dat     (fault_in),
    .pop_vld      (cp_wr && (i_copro_crn == CRN_FAULT_POP)),
    .clr_overflow (cp_wr && (i_copro_crn == CRN_FAULT_INFO)),
    .head_dat     (fault_head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .overflow     (fifo_overflow)
  );

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (i_copro_crn)
      CRN_ID:           rd_mux = ID_VALUE;
      CRN_CTRL:         rd_mux = {29'd0, ctrl};
      CRN_CACHEABLE:    rd_mux = 32'(cacheable);
      CRN_UPDATEABLE:   rd_mux = 32'(updateable);
      CRN_DISRUPTIVE:   rd_mux = 32'(disruptive);
      CRN_FAULT_STATUS: rd_mux = {24'd0, fault_head.status};
      CRN_FAULT_ADDR:   rd_mux = fault_head.address;
      CRN_FAULT_INFO:   rd_mux = {fifo_overflow, 23'd0, count8};
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl                <= '0;
      cacheable           <= '0;
      updateable          <= '0;
      disruptive          <= '0;
      o_copro_read_data   <= '0;
      o_access_cacheable  <= 1'b0;
      o_access_updateable <= 1'b0;
    end else begin
      if (cp_wr) begin
        case (i_copro_crn)
          CRN_CTRL:       ctrl       <= i_copro_write_data[2:0];
          CRN_CACHEABLE:  cacheable  <= i_copro_write_data[REGION_BITS-1:0];
          CRN_UPDATEABLE: updateable <= i_copro_write_data[REGION_BITS-1:0];
          CRN_DISRUPTIVE: disruptive <= i_copro_write_data[REGION_BITS-1:0];
          default: ;
        endcase
      end
      if (cp_rd) o_copro_read_data <= rd_mux;
      if (lookup_vld) begin
        o_access_cacheable  <= hit_cacheable;
        o_access_updateable <= hit_updateable;
      end
    end
  end

  // Flush handshake. An ack only counts while the request is up, which also
  // discards acks in IDLE and during the one-cycle drop between back-to-back flushes.
  flush_state_t flush_state;
  logic         flush_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_state       <= FL_IDLE;
      flush_pending     <= 1'b0;
      o_cache_flush_req <= 1'b0;
    end else begin
      case (flush_state)
        FL_IDLE: begin
          flush_pending <= 1'b0;
          if (flush_cmd) begin
            flush_state       <= FL_REQ;
            o_cache_flush_req <= 1'b1;
          end
        end
        FL_REQ: begin
          if (i_cache_flush_ack && o_cache_flush_req) begin
            o_cache_flush_req <= 1'b0;
            if (flush_pending) begin
              flush_pending <= flush_cmd;
            end else if (!flush_cmd) begin
              flush_state <= FL_IDLE;
            end
          end else begin
            o_cache_flush_req <= 1'b1;
            if (flush_cmd) flush_pending <= 1'b1;
          end
        end
        default: begin
          flush_state       <= FL_IDLE;
          flush_pending     <= 1'b0;
          o_cache_flush_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_cache_enable  = ctrl[0];
  assign o_fault_pending = !fifo_empty;

endmodule

// File: tb/tb_a25_copro15_ctrl.sv
// Directed bench for a25_copro15_ctrl: table of one-cycle vectors plus a reset-during-flush sequence.
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: exercised through i_access_stall vectors in the table.
module tb_a25_copro15_ctrl;
  import a25_copro15_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [3:0]  cnum;
  logic [3:0]  crn;
  logic [1:0]  op;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        flt;
  logic [7:0]  fst;
  logic [31:0] fadr;
  logic        avld;
  logic [31:0] aadr;
  logic        cach;
  logic        upd;
  logic        cen;
  logic        freq;
  logic        fack;
  logic        fpend;

  a25_copro15_ctrl dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_access_stall      (stall),
    .i_copro_num         (cnum),
    .i_copro_crn         (crn),
    .i_copro_operation   (op),
    .i_copro_write_data  (wdat),
    .o_copro_read_data   (rdat),
    .i_fault             (flt),
    .i_fault_status      (fst),
    .i_fault_address     (fadr),
    .i_access_valid      (avld),
    .i_access_address    (aadr),
    .o_access_cacheable  (cach),
    .o_access_updateable (upd),
    .o_cache_enable      (cen),
    .o_cache_flush_req   (freq),
    .i_cache_flush_ack   (fack),
    .o_fault_pending     (fpend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_NO, S_RD, S_CA, S_UP, S_RQ, S_PD, S_EN} sel_t;

  typedef struct {
    logic        st;
    logic [3:0]  cn;
    logic [1:0]  op;
    logic [3:0]  crn;
    logic [31:0] wd;
    logic        av;
    logic [31:0] aa;
    logic        fl;
    logic [7:0]  fs;
    logic        ack;
    sel_t        sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_total;
  int   n_pass;

  localparam logic [1:0] NO = 2'd0;
  localparam logic [1:0] RD = 2'd1;
  localparam logic [1:0] WR = 2'd2;

  task automatic add(input logic st, input logic [3:0] cn, input logic [1:0] o, input logic [3:0] r,
                     input logic [31:0] wd, input logic av, input logic [31:0] aa, input logic fl,
                     input logic [7:0] fs, input logic ack, input sel_t sel, input logic [31:0] exp);
    vec_t v;
    v.st = st; v.cn = cn; v.op = o; v.crn = r; v.wd = wd; v.av = av; v.aa = aa;
    v.fl = fl; v.fs = fs; v.ack = ack; v.sel = sel; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    stall = v.st; cnum = v.cn; op = v.op; crn = v.crn; wdat = v.wd;
    avld = v.av; aadr = v.aa; flt = v.fl; fst = v.fs; fadr = 32'h1000 + 32'(v.fs);
    fack = v.ack;
  endtask

  task automatic idle();
    stall = 1'b0; cnum = 4'd15; op = NO; crn = 4'd0; wdat = '0;
    avld = 1'b0; aadr = '0; flt = 1'b0; fst = '0; fadr = '0; fack = 1'b0;
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_RD:    return rdat;
      S_CA:    return {31'd0, cach};
      S_UP:    return {31'd0, upd};
      S_RQ:    return {31'd0, freq};
      S_PD:    return {31'd0, fpend};
      S_EN:    return {31'd0, cen};
      default: return '0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle();

    // Basic reads and the foreign-coprocessor filter.
    add(0, 15, RD, 0, 0, 0, 0, 0, 0, 0, S_RD, 32'h4156_0301);
    add(0, 15, RD, 3, 0, 0, 0, 0, 0, 0, S_RD, 32'h0);
    add(0, 14, RD, 0, 0, 0, 0, 0, 0, 0, S_RD, 32'h0);
    // Region lookup with 2MB regions.
    add(0, 15, WR, 3, 32'h5, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, WR, 4, 32'h4, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, NO, 0, 0, 1, 32'h0040_0000, 0, 0, 0, S_CA, 1);
    add(0, 15, NO, 0, 0, 1, 32'h0020_0000, 0, 0, 0, S_CA, 0);
    add(0, 15, NO, 0, 0, 1, 32'h0040_0000, 0, 0, 0, S_UP, 1);
    add(0, 15, NO, 0, 0, 1, 32'h1000_0000, 0, 0, 0, S_CA, 0);
    add(0, 15, NO, 0, 0, 1, 32'h0000_0000, 0, 0, 0, S_CA, 1);
    add(0, 15, NO, 0, 0, 0, 32'h0020_0000, 0, 0, 0, S_CA, 1);
    add(0, 15, RD, 3, 0, 0, 0, 0, 0, 0, S_RD, 32'h5);
    add(0, 15, RD, 4, 0, 0, 0, 0, 0, 0, S_RD, 32'h4);
    // Disruptive region triggers flush only with ctrl[0] set.
    add(0, 15, WR, 5, 32'h2, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, NO, 0, 0, 1, 32'h0030_0000, 0, 0, 0, S_RQ, 0);
    add(0, 15, WR, 2, 32'h1, 0, 0, 0, 0, 0, S_EN, 1);
    add(0, 15, NO, 0, 0, 1, 32'h0030_0000, 0, 0, 0, S_RQ, 1);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 1, S_RQ, 0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 0, S_RQ, 0);
    add(0, 15, WR, 2, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, S_EN, 0);
    add(0, 15, RD, 2, 0, 0, 0, 0, 0, 0, S_RD, 32'h6);
    // Back-to-back flush: pending command merges, req drops one cycle.
    add(0, 15, WR, 1, 0, 0, 0, 0, 0, 0, S_RQ, 1);
    add(0, 15, WR, 1, 0, 0, 0, 0, 0, 0, S_RQ, 1);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 1, S_RQ, 0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 0, S_RQ, 1);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 1, S_RQ, 0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 0, S_RQ, 0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 1, S_RQ, 0);
    // Fault FIFO: overflow on the fifth push, pop, clear, full push+pop.
    add(0, 15, NO, 0, 0, 0, 0, 1, 1, 0, S_PD, 1);
    add(0, 15, NO, 0, 0, 0, 0, 1, 2, 0, S_NO, 0);
    add(0, 15, NO, 0, 0, 0, 0, 1, 3, 0, S_NO, 0);
    add(0, 15, NO, 0, 0, 0, 0, 1, 4, 0, S_NO, 0);
    add(0, 15, NO, 0, 0, 0, 0, 1, 5, 0, S_NO, 0);
    add(0, 15, RD, 9, 0, 0, 0, 0, 0, 0, S_RD, 32'h8000_0004);
    add(0, 15, RD, 6, 0, 0, 0, 0, 0, 0, S_RD, 32'h1);
    add(0, 15, RD, 7, 0, 0, 0, 0, 0, 0, S_RD, 32'h1001);
    add(0, 15, WR, 8, 0, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, RD, 6, 0, 0, 0, 0, 0, 0, S_RD, 32'h2);
    add(0, 15, WR, 9, 0, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, RD, 9, 0, 0, 0, 0, 0, 0, S_RD, 32'h3);
    add(0, 15, NO, 0, 0, 0, 0, 1, 6, 0, S_NO, 0);
    add(0, 15, WR, 8, 0, 0, 0, 1, 7, 0, S_NO, 0);
    add(0, 15, RD, 9, 0, 0, 0, 0, 0, 0, S_RD, 32'h4);
    add(0, 15, RD, 6, 0, 0, 0, 0, 0, 0, S_RD, 32'h3);
    add(0, 15, RD, 7, 0, 0, 0, 0, 0, 0, S_RD, 32'h1003);
    for (int k = 0; k < 4; k++) add(0, 15, WR, 8, 0, 0, 0, 0, 0, 0, S_NO, 0);
    add(0, 15, RD, 6, 0, 0, 0, 0, 0, 0, S_RD, 32'h0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 0, S_PD, 0);
    add(0, 15, WR, 8, 0, 0, 0, 0, 0, 0, S_PD, 0);
    // Stall freezes state; flush handshake still completes.
    add(0, 15, RD, 0, 0, 0, 0, 0, 0, 0, S_RD, 32'h4156_0301);
    add(1, 15, WR, 2, 32'h1, 0, 0, 0, 0, 0, S_EN, 0);
    add(1, 15, NO, 0, 0, 0, 0, 1, 9, 0, S_PD, 0);
    add(1, 15, NO, 0, 0, 1, 32'h0, 0, 0, 0, S_CA, 0);
    add(1, 15, RD, 3, 0, 0, 0, 0, 0, 0, S_RD, 32'h4156_0301);
    add(0, 15, RD, 2, 0, 0, 0, 0, 0, 0, S_RD, 32'h6);
    add(0, 15, WR, 1, 0, 0, 0, 0, 0, 0, S_RQ, 1);
    add(1, 15, NO, 0, 0, 0, 0, 0, 0, 1, S_RQ, 0);
    add(1, 15, WR, 1, 0, 0, 0, 0, 0, 0, S_RQ, 0);
    add(0, 15, NO, 0, 0, 0, 0, 0, 0, 0, S_RQ, 0);

    repeat (2) @(negedge clk);
    check("rst_rdata", rdat, 32'h0);
    check("rst_flush_req", {31'd0, freq}, 32'h0);
    check("rst_fault_pending", {31'd0, fpend}, 32'h0);
    check("rst_cacheable", {31'd0, cach}, 32'h0);
    check("rst_updateable", {31'd0, upd}, 32'h0);
    check("rst_cache_enable", {31'd0, cen}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      if (tbl[i].sel != S_NO)
        check($sformatf("vec%0d_%s", i, tbl[i].sel.name()), observe(tbl[i].sel), tbl[i].exp);
    end

    // Reset asserted while a flush request is outstanding.
    idle();
    op  = WR;
    crn = CRN_FLUSH;
    @(negedge clk);
    check("rst_mid_req_up", {31'd0, freq}, 32'h1);
    idle();
    #2 rst_n = 1'b0;
    #1 check("rst_mid_req_async", {31'd0, freq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fack  = 1'b1;
    @(negedge clk);
    check("rst_mid_late_ack", {31'd0, freq}, 32'h0);
    idle();
    op  = RD;
    crn = CRN_CACHEABLE;
    @(negedge clk);
    check("rst_mid_area_cleared", rdat, 32'h0);
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
